// File: rtl/zigzag_reorder_buffer_pkg.sv
// Shared codec definitions: block geometry, coefficient type and the
// zigzag-to-raster scan table used by every stage that reorders coefficients.
package zigzag_reorder_buffer_pkg;

   localparam int BLOCK_SIZE = 64;
   localparam int COEFF_W    = 12;

   typedef logic signed [COEFF_W-1:0] coeff_t;

   // Entry k is the raster position of the k-th coefficient in scan order.
   localparam logic [5:0] ZZ_TO_RASTER [BLOCK_SIZE] = '{
       6'd0,  6'd8,  6'd1,  6'd2,  6'd9, 6'd16, 6'd24, 6'd17, 6'd10,  6'd3,
       6'd4, 6'd11, 6'd18, 6'd25, 6'd32, 6'd40, 6'd33, 6'd26, 6'd19, 6'd12,
       6'd5,  6'd6, 6'd13, 6'd20, 6'd27, 6'd34, 6'd41, 6'd48, 6'd56, 6'd49,
      6'd42, 6'd35, 6'd28, 6'd21, 6'd14,  6'd7, 6'd15, 6'd22, 6'd29, 6'd36,
      6'd43, 6'd50, 6'd57, 6'd58, 6'd51, 6'd44, 6'd37, 6'd30, 6'd23, 6'd31,
      6'd38, 6'd45, 6'd52, 6'd59, 6'd60, 6'd53, 6'd46, 6'd39, 6'd47, 6'd54,
      6'd61, 6'd62, 6'd55, 6'd63
   };

endpackage

// File: rtl/zigzag_reorder_buffer_ram.sv
// Simple dual-port coefficient store holding two 64-entry banks; one write
// port, one registered read port.
module coeff_pingpong_ram #(
   parameter int WIDTH      = 12,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  clk_i,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]      wr_data_i,
   input  logic                  rd_en_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [WIDTH-1:0]      rd_data_o
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // NOTE: no reset on the array or read register; bank full flags guard every
   // read, so contents never need a known value and the array can map to RAM.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
      if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/zigzag_reorder_buffer.sv
// Ping-pong reorder buffer: raster-order coefficients in, zigzag-order out.
// The writer fills one bank while a three-stage read pipeline drains the other.
module zigzag_reorder_buffer
   import zigzag_reorder_buffer_pkg::*;
#(
   parameter int COEFF_WIDTH = $bits(coeff_t)
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   s_valid_in,
   output logic                   s_ready_out,
   input  logic [COEFF_WIDTH-1:0] s_data_in,
   output logic                   m_valid_out,
   input  logic                   m_ready_in,
   output logic [COEFF_WIDTH-1:0] m_data_out,
   output logic [5:0]             m_index_out,
   output logic                   m_last_out
);

   localparam logic [5:0] LAST_IDX = 6'(BLOCK_SIZE - 1);

   logic [1:0] full_q, full_d;
   logic       wr_bank_q, wr_bank_d;
   logic [5:0] wr_cnt_q, wr_cnt_d;
   logic       iss_bank_q, iss_bank_d;
   logic [5:0] iss_cnt_q, iss_cnt_d;
   logic       rd_bank_q, rd_bank_d;

   logic       iss_vld_q;
   logic [6:0] iss_addr_q;
   logic [5:0] iss_tag_q;
   logic       ram_vld_q;
   logic [5:0] ram_tag_q;

   logic                   m_valid_q;
   logic [COEFF_WIDTH-1:0] m_data_q;
   logic [5:0]             m_index_q;
   logic                   m_last_q;

   logic                   en;
   logic                   s_ready;
   logic                   wr_fire;
   logic                   iss_fire;
   logic                   rel_fire;
   logic [COEFF_WIDTH-1:0] ram_rd_data;

   assign s_ready  = !full_q[wr_bank_q];
   assign en       = !m_valid_q || m_ready_in;
   assign wr_fire  = s_valid_in && s_ready;
   assign iss_fire = en && full_q[iss_bank_q];
   assign rel_fire = m_valid_q && m_ready_in && m_last_q;

   // NOTE: every next-state value is defaulted to its current value first so no
   // path through this block leaves a variable unassigned (which infers a latch).
   always_comb begin
      full_d     = full_q;
      wr_bank_d  = wr_bank_q;
      wr_cnt_d   = wr_cnt_q;
      iss_bank_d = iss_bank_q;
      iss_cnt_d  = iss_cnt_q;
      rd_bank_d  = rd_bank_q;

      // Release and write completion always target different banks.
      if (rel_fire) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
      end

      if (wr_fire) begin
         wr_cnt_d = wr_cnt_q + 6'd1;
         if (wr_cnt_q == LAST_IDX) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
         end
      end

      if (iss_fire) begin
         iss_cnt_d = iss_cnt_q + 6'd1;
         if (iss_cnt_q == LAST_IDX) iss_bank_d = ~iss_bank_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         full_q     <= '0;
         wr_bank_q  <= 1'b0;
         wr_cnt_q   <= '0;
         iss_bank_q <= 1'b0;
         iss_cnt_q  <= '0;
         rd_bank_q  <= 1'b0;
      end else begin
         full_q     <= full_d;
         wr_bank_q  <= wr_bank_d;
         wr_cnt_q   <= wr_cnt_d;
         iss_bank_q <= iss_bank_d;
         iss_cnt_q  <= iss_cnt_d;
         rd_bank_q  <= rd_bank_d;
      end
   end

   // Issue, RAM-read and output stages all advance together under en.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         iss_vld_q  <= 1'b0;
         iss_addr_q <= '0;
         iss_tag_q  <= '0;
         ram_vld_q  <= 1'b0;
         ram_tag_q  <= '0;
         m_valid_q  <= 1'b0;
         m_data_q   <= '0;
         m_index_q  <= '0;
         m_last_q   <= 1'b0;
      end else if (en) begin
         iss_vld_q  <= iss_fire;
         iss_addr_q <= {iss_bank_q, ZZ_TO_RASTER[iss_cnt_q]};
         iss_tag_q  <= iss_cnt_q;
         ram_vld_q  <= iss_vld_q;
         ram_tag_q  <= iss_tag_q;
         m_valid_q  <= ram_vld_q;
         m_data_q   <= ram_rd_data;
         m_index_q  <= ram_tag_q;
         m_last_q   <= ram_vld_q && (ram_tag_q == LAST_IDX);
      end
   end

   coeff_pingpong_ram #(
      .WIDTH      (COEFF_WIDTH),
      .ADDR_WIDTH (7)
   ) u_ram (
      .clk_i     (clk_in),
      .wr_en_i   (wr_fire),
      .wr_addr_i ({wr_bank_q, wr_cnt_q}),
      .wr_data_i (s_data_in),
      .rd_en_i   (en),
      .rd_addr_i (iss_addr_q),
      .rd_data_o (ram_rd_data)
   );

   assign s_ready_out = s_ready;
   assign m_valid_out = m_valid_q;
   assign m_data_out  = m_data_q;
   assign m_index_out = m_index_q;
   assign m_last_out  = m_last_q;

endmodule

// File: tb/tb_zigzag_reorder_buffer.sv
// Directed bench for zigzag_reorder_buffer: a stream-level reference model
// builds each block's scan order independently and scores every output.
module tb_zigzag_reorder_buffer;

   typedef struct packed {
      logic [11:0] data;
      logic [5:0]  idx;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid;
   logic        s_ready;
   logic [11:0] s_data;
   logic        m_valid;
   logic        m_ready;
   logic [11:0] m_data;
   logic [5:0]  m_index;
   logic        m_last;

   int n_checks = 0;
   int n_fail   = 0;

   int          zz [64];
   logic [11:0] in_q [$];
   logic [11:0] acc_blk [$];
   exp_t        exp_q [$];
   logic [11:0] out_log [$];

   int cyc = 0;
   int n_acc, n_out, n_drop, n_last_seen;
   int first_valid_cyc, first_out_cyc, last_out_cyc, last_acc_cyc;
   bit saw_last, ready_at_last, cur_s_ready, was_stalled;
   logic [11:0] prev_data;
   logic [5:0]  prev_index;
   logic        prev_last;

   zigzag_reorder_buffer dut (
      .clk_in      (clk),
      .rst_in      (rst_n),
      .s_valid_in  (s_valid),
      .s_ready_out (s_ready),
      .s_data_in   (s_data),
      .m_valid_out (m_valid),
      .m_ready_in  (m_ready),
      .m_data_out  (m_data),
      .m_index_out (m_index),
      .m_last_out  (m_last)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scan order walks anti-diagonals; odd diagonals run bottom-left to top-right.
   function automatic void build_zz();
      int k = 0;
      for (int s = 0; s < 15; s++) begin
         int lo = (s > 7) ? s - 7 : 0;
         int hi = (s < 7) ? s : 7;
         if (s % 2 == 1) begin
            for (int r = hi; r >= lo; r--) begin zz[k] = r * 8 + (s - r); k++; end
         end else begin
            for (int r = lo; r <= hi; r++) begin zz[k] = r * 8 + (s - r); k++; end
         end
      end
   endfunction

   task automatic clear_stats();
      n_acc = 0; n_out = 0; n_drop = 0; n_last_seen = 0;
      first_valid_cyc = -1; first_out_cyc = -1; last_out_cyc = -1; last_acc_cyc = -1;
      saw_last = 0; ready_at_last = 0;
      out_log.delete();
   endtask

   task automatic reset_model();
      in_q.delete(); acc_blk.delete(); exp_q.delete();
      was_stalled = 0;
      clear_stats();
   endtask

   task automatic apply_reset();
      @(negedge clk);
      s_valid = 1'b0; m_ready = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      reset_model();
   endtask

   // One clock: drive at negedge, sample at negedge+1, score handshakes due at the next posedge.
   task automatic cycle(input bit rand_v, input int ready_mode);
      exp_t e;
      @(negedge clk);
      cyc++;
      s_valid = (in_q.size() > 0) && (!rand_v || $urandom_range(1, 0) == 1);
      s_data  = (in_q.size() > 0) ? in_q[0] : 12'h0;
      m_ready = (ready_mode == 2) ? 1'($urandom_range(1, 0)) : (ready_mode == 1);
      #1;
      cur_s_ready = s_ready;
      if (was_stalled) begin
         check("hold_data",  32'(m_data),  32'(prev_data));
         check("hold_index", 32'(m_index), 32'(prev_index));
         check("hold_last",  32'(m_last),  32'(prev_last));
      end
      if (s_valid && !s_ready) n_drop++;
      if (s_valid && s_ready) begin
         acc_blk.push_back(in_q.pop_front());
         n_acc++;
         last_acc_cyc = cyc;
         if (acc_blk.size() == 64) begin
            for (int k = 0; k < 64; k++) begin
               e.data = acc_blk[zz[k]];
               e.idx  = 6'(k);
               exp_q.push_back(e);
            end
            acc_blk.delete();
         end
      end
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_out", 32'(m_data), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("out_data",  32'(m_data),  32'(e.data));
            check("out_index", 32'(m_index), 32'(e.idx));
            check("out_last",  32'(m_last),  32'(e.idx == 6'd63));
         end
         out_log.push_back(m_data);
         if (first_out_cyc < 0) first_out_cyc = cyc;
         last_out_cyc = cyc;
         n_out++;
         if (m_last) begin
            n_last_seen++;
            saw_last = 1;
            ready_at_last = s_ready;
         end
      end
      was_stalled = m_valid && !m_ready;
      prev_data = m_data; prev_index = m_index; prev_last = m_last;
   endtask

   task automatic run_until_empty(input bit rand_v, input int ready_mode, input int budget);
      for (int i = 0; i < budget && (in_q.size() > 0 || exp_q.size() > 0); i++)
         cycle(rand_v, ready_mode);
      check("drain_timeout", 32'(exp_q.size() + in_q.size()), 32'd0);
   endtask

   task automatic check_log(input string tag, input int pos, input logic [11:0] exp);
      if (pos < out_log.size()) check(tag, 32'(out_log[pos]), 32'(exp));
      else check(tag, 32'hFFFF_FFFF, 32'(exp));
   endtask

   initial begin
      int head [11] = '{0, 8, 1, 2, 9, 16, 24, 17, 10, 3, 4};
      int tail [6]  = '{47, 54, 61, 62, 55, 63};

      s_valid = 1'b0; m_ready = 1'b0; s_data = '0; rst_n = 1'b0;
      build_zz();
      reset_model();
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data",  32'(m_data),  32'd0);
      check("rst_m_index", 32'(m_index), 32'd0);
      check("rst_m_last",  32'(m_last),  32'd0);
      check("rst_s_ready", 32'(s_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Single block, data equals raster index.
      for (int i = 0; i < 64; i++) in_q.push_back(12'(i));
      run_until_empty(0, 1, 400);
      check("t1_latency", 32'(first_valid_cyc - last_acc_cyc), 32'd4);
      check("t1_n_out", 32'(n_out), 32'd64);
      check("t1_n_last", 32'(n_last_seen), 32'd1);
      for (int i = 0; i < 11; i++) check_log("t1_head", i, 12'(head[i]));
      for (int i = 0; i < 6; i++) check_log("t1_tail", 58 + i, 12'(tail[i]));

      // Two back-to-back blocks with continuous valid.
      clear_stats();
      for (int i = 0; i < 64; i++) in_q.push_back(12'(i));
      for (int i = 0; i < 64; i++) in_q.push_back(12'(100 + i));
      run_until_empty(0, 1, 600);
      check("t2_n_out", 32'(n_out), 32'd128);
      check("t2_no_gap", 32'(last_out_cyc - first_out_cyc), 32'd127);
      check("t2_no_ready_drop", 32'(n_drop), 32'd0);
      check_log("t2_blk1_0", 64, 12'd100);
      check_log("t2_blk1_1", 65, 12'd108);
      check_log("t2_blk1_2", 66, 12'd101);

      // Downstream stalled: only two blocks fit.
      clear_stats();
      for (int i = 0; i < 130; i++) in_q.push_back(12'(i + 1000));
      for (int i = 0; i < 140; i++) cycle(0, 0);
      check("t3_accepted", 32'(n_acc), 32'd128);
      check("t3_ready_low", 32'(cur_s_ready), 32'd0);
      check("t3_left", 32'(in_q.size()), 32'd2);
      for (int i = 0; i < 200 && !saw_last; i++) cycle(0, 1);
      check("t3_saw_last", 32'(saw_last), 32'd1);
      check("t3_ready_at_release", 32'(ready_at_last), 32'd0);
      cycle(0, 1);
      check("t3_ready_after_release", 32'(cur_s_ready), 32'd1);
      run_until_empty(0, 1, 400);
      check("t3_n_out", 32'(n_out), 32'd128);
      apply_reset();

      // Extreme signed values at raster 8 and 63.
      for (int i = 0; i < 64; i++) in_q.push_back(12'(i));
      in_q[8]  = 12'h800;
      in_q[63] = 12'h7FF;
      run_until_empty(0, 1, 400);
      check_log("t5_zz0", 0, 12'h000);
      check_log("t5_neg_zz1", 1, 12'h800);
      check_log("t5_zz2", 2, 12'h001);
      check_log("t5_pos_zz63", 63, 12'h7FF);

      // Random handshakes on both sides, random data.
      clear_stats();
      for (int i = 0; i < 192; i++) in_q.push_back(12'($urandom));
      run_until_empty(1, 2, 4000);
      check("t4_accepted", 32'(n_acc), 32'd192);
      check("t4_n_out", 32'(n_out), 32'd192);
      check("t4_n_last", 32'(n_last_seen), 32'd3);

      // Reset in the middle of a write and a read.
      clear_stats();
      for (int i = 0; i < 104; i++) in_q.push_back(12'(i + 2000));
      for (int i = 0; i < 400 && n_acc < 104; i++) cycle(0, 0);
      check("t6_accepted", 32'(n_acc), 32'd104);
      for (int i = 0; i < 100 && n_out < 10; i++) cycle(0, 1);
      check("t6_reads", 32'(n_out), 32'd10);
      @(negedge clk);
      m_ready = 1'b0; s_valid = 1'b0;
      #2;
      check("t6_pre_valid", 32'(m_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6_m_valid", 32'(m_valid), 32'd0);
      check("t6_m_data",  32'(m_data),  32'd0);
      check("t6_m_index", 32'(m_index), 32'd0);
      check("t6_m_last",  32'(m_last),  32'd0);
      check("t6_s_ready", 32'(s_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      reset_model();
      for (int i = 0; i < 64; i++) in_q.push_back(12'(200 + i));
      run_until_empty(0, 1, 400);
      check("t6_n_out", 32'(n_out), 32'd64);
      check_log("t6_after_0", 0, 12'd200);
      check_log("t6_after_1", 1, 12'd208);
      check_log("t6_after_2", 2, 12'd201);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/zigzag_reorder_buffer.md
# zigzag_reorder_buffer

Double-buffered coefficient reorder stage between the quantizer and the entropy coder. It accepts quantized 8x8 coefficients in raster order, one per valid/ready handshake. It emits each completed block in zigzag scan order, using the codec's standard zigzag-to-raster table. Two banks let the writer fill one block while the reader drains the other, which sustains one coefficient per cycle.

## Interface
- COEFF_WIDTH, 12: signed coefficient width.
- clk_in  input  1  single clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- s_valid_in  input  1  upstream coefficient valid.
- s_ready_out  output  1  buffer can accept a coefficient.
- s_data_in  input  COEFF_WIDTH  coefficient, in raster order within the block.
- m_valid_out  output  1  output coefficient valid.
- m_ready_in  input  1  downstream accepts the output.
- m_data_out  output  COEFF_WIDTH  coefficient, in zigzag order.
- m_index_out  output  6  zigzag index (0..63) of m_data_out.
- m_last_out  output  1  high when m_index_out == 63.

## Operation
- Storage: 2 banks x 64 entries; bank address is {bank, raster_idx[5:0]}.
- Each bank has a full flag. All flags are 0 after reset.
- Write side:
  - s_ready_out = !full[wr_bank] (combinational).
  - On each s_valid_in && s_ready_out, write s_data_in at {wr_bank, wr_cnt}, then wr_cnt++.
  - On the write with wr_cnt == 63: set full[wr_bank], toggle wr_bank, wrap wr_cnt to 0.
- Read side has three stages: issue, RAM read, output.
  - Pipeline enable: en = !m_valid_out || m_ready_in.
  - Issue fires when en && full[iss_bank]. It presents RAM address {iss_bank, ZZ[iss_cnt]} and a tag {iss_cnt} downstream, then iss_cnt++.
  - On issue with iss_cnt == 63: toggle iss_bank, wrap iss_cnt.
  - Read data and tag move through registered stages under en. A bubble is propagated when issue does not fire.
- Bank release: on the output handshake with m_last_out == 1, clear full[rd_bank] and toggle rd_bank.
- Simultaneous events:
  - A write completing one bank and a release of the other bank in the same cycle both take effect.
  - The write to a just-released bank waits until the next cycle, because s_ready_out sees the registered flag.
- Banks are never read and written concurrently. Issue reads only full banks; writes go only to non-full banks.
- The ZZ table maps zigzag index to raster index. It begins 0,8,1,2,9,16,24,17,10,3,4 and ends 47,54,61,62,55,63.
- No arithmetic on data. Coefficients pass through bit-exact.

## Timing
- Reset values:
  - m_valid_out = 0, m_data_out = 0, m_index_out = 0, m_last_out = 0.
  - wr_bank, iss_bank and rd_bank = 0; wr_cnt and iss_cnt = 0; full flags = 0.
  - s_ready_out = 1.
- Latency: m_valid_out first rises 3 clock edges after the edge that accepted the 64th coefficient of a block:
  - +1: full flag seen by issue.
  - +2: RAM read.
  - +3: output register.
- Throughput: 1 coefficient per cycle on each side when unstalled. Back-to-back full blocks stream with no bubble at the bank boundary.
- Holding: while m_valid_out && !m_ready_in, m_data_out, m_index_out and m_last_out hold stable.
- Both banks full: s_ready_out = 0 until the release handshake. It returns to 1 on the following cycle.
- Reset mid-block: a partially written or partially read block is discarded. Outputs go to their reset values immediately (asynchronous reset).

## Structure
- Shared codec package holds:
  - ZZ_TO_RASTER: localparam array [64] of 6-bit values (same table as the rest of the codec).
  - BLOCK_SIZE = 64.
  - The coefficient typedef.
- Sub-module coeff_pingpong_ram: simple dual-port RAM, 128 x COEFF_WIDTH, registered read, no reset on contents, read enable tied to en.
- Top level holds the counters, bank flags, pipeline valid and tag registers, and the output register. Expected size is about 200 lines.

## Test plan
- Single block, data = raster index, m_ready_in = 1 -> outputs 0,8,1,2,9,16,24,17,... through 55,63. m_index_out runs 0..63, m_last_out is high only on the 64th output, and the first m_valid_out comes 3 edges after the last input.
- Two back-to-back blocks (bank 0 data = idx, bank 1 data = 100+idx), continuous valid -> 128 outputs with no gaps. The second block starts with 100,108,101. s_ready_out never drops.
- m_ready_in = 0 throughout, 130 offered inputs -> exactly 128 accepted. s_ready_out drops after input 128. After one full block drains, s_ready_out reasserts 1 cycle after the last handshake.
- Random m_ready_in (50%) and random s_valid_in -> the output stream matches a reference model. Outputs stay stable while stalled, and no coefficient is lost or duplicated.
- Negative values (-2048, 2047) at raster positions 8 and 63 -> they appear bit-exact at zigzag indices 1 and 63.
- Assert rst_in low after 40 writes and 10 reads -> all outputs clear immediately. A fresh block after reset produces the correct order starting from bank 0.
